// File: rtl/lfb_pkg.sv
// Shared types and constants for the line fill buffer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package lfb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } lfb_state_t;

  localparam int LINE_BITS  = 256;
  localparam int OFFSET_W   = 3;
  localparam int BYTE_OFF_W = 2;

  // Bit position of the LSB of word idx; word 0 sits in the MSBs of the
  // line so it lines up with the downstream word-select mux.
  function automatic logic [7:0] word_lsb(input logic [OFFSET_W-1:0] idx);
    return 8'd224 - {idx, 5'b0_0000};
  endfunction

endpackage

// File: rtl/line_fill_buffer_line_assembler.sv
// Beat-to-word writer: places each memory beat at (offset + k) mod 8 and captures the critical word.
// Latency: a beat lands in the line register 1 cycle after acceptance; crit_valid pulses 1 cycle after beat 0.
// Backpressure: none; every beat presented with beat=1 is written.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : clears the beat counter for a new miss
//   offset      : critical word offset of the current miss
//   beat, data  : accepted memory beat and its payload
//   line        : line under assembly (unwritten words keep prior contents)
//   last        : combinational, high while the final beat is being accepted
//   crit_valid  : one-cycle pulse with crit_data = first beat
module line_fill_buffer_line_assembler
  import lfb_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OFFSET_W-1:0]   offset,
  input  logic                  beat,
  input  logic [WORD_W-1:0]     data,
  output logic [LINE_BITS-1:0]  line,
  output logic                  last,
  output logic                  crit_valid,
  output logic [WORD_W-1:0]     crit_data
);

  logic [OFFSET_W-1:0] count;
  logic [OFFSET_W-1:0] idx;

  // 3-bit addition wraps naturally inside the line.
  assign idx  = offset + count;
  assign last = beat && (count == OFFSET_W'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      line       <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
    end else begin
      crit_valid <= beat && (count == '0);
      if (start) begin
        count <= '0;
      end else if (beat) begin
        line[word_lsb(idx) +: WORD_W] <= data;
        count                         <= count + 1'b1;
        if (count == '0) begin
          crit_data <= data;
        end
      end
    end
  end

endmodule

// File: rtl/line_fill_buffer.sv
// Miss line fill: fetches a 256-bit line as 8 critical-word-first beats and presents it to the data array.
// Latency: miss accept c0, mem_req c1, beats c2..c9, crit_valid c3, fill_valid c10 (no stalls).
// Backpressure: miss_ready only in IDLE; mem_req waits on mem_req_ready; beats always sunk in FILL; line held until fill_ready.
//
// Ports:
//   clk, rst                               : clock, synchronous active-high reset
//   miss_valid/miss_ready/miss_addr        : miss request handshake
//   mem_req_valid/mem_req_ready/addr       : memory read request (wrap-ordered burst)
//   mem_rsp_valid/mem_rsp_data             : memory beats, no backpressure
//   crit_valid/crit_data                   : early critical word pulse
//   fill_valid/fill_ready/line/addr/offset : assembled line handshake
module line_fill_buffer
  import lfb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_W-1:0]     miss_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_W-1:0]     mem_rsp_data,
  output logic                  crit_valid,
  output logic [WORD_W-1:0]     crit_data,
  output logic                  fill_valid,
  input  logic                  fill_ready,
  output logic [LINE_BITS-1:0]  fill_line,
  output logic [ADDR_W-1:0]     fill_addr,
  output logic [OFFSET_W-1:0]   fill_offset
);

  localparam int LINE_OFF_W = OFFSET_W + BYTE_OFF_W;

  lfb_state_t state, state_nxt;
  logic       start;
  logic       beat;
  logic       last;

  // Byte offset within the word is irrelevant to a line fetch.
  logic unused_byte_bits;
  assign unused_byte_bits = ^miss_addr[BYTE_OFF_W-1:0];

  // Stray beats outside FILL are dropped here, before they reach the line.
  assign beat = (state == FILL) && mem_rsp_valid;

  // Request address is rebuilt from the latched fields so it stays stable in REQ.
  assign mem_req_addr = {fill_addr[ADDR_W-1:LINE_OFF_W], fill_offset, {BYTE_OFF_W{1'b0}}};

  always_comb begin
    state_nxt     = state;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    fill_valid    = 1'b0;
    start         = 1'b0;
    case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = FILL;
      end
      FILL: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        fill_valid = 1'b1;
        if (fill_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fill_addr   <= '0;
      fill_offset <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        fill_addr   <= {miss_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
        fill_offset <= miss_addr[LINE_OFF_W-1:BYTE_OFF_W];
      end
    end
  end

  line_fill_buffer_line_assembler #(
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_assembler (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .offset     (fill_offset),
    .beat       (beat),
    .data       (mem_rsp_data),
    .line       (fill_line),
    .last       (last),
    .crit_valid (crit_valid),
    .crit_data  (crit_data)
  );

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed self-checking bench for line_fill_buffer.
// Latency: checks the 10-cycle miss-to-fill path plus stalled variants.
// Backpressure: exercises mem_req_ready stalls, beat gaps and fill_ready hold-off.
module tb_line_fill_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         fill_valid;
  logic         fill_ready;
  logic [255:0] fill_line;
  logic [31:0]  fill_addr;
  logic [2:0]   fill_offset;

  int n_tests = 0;
  int n_fail  = 0;
  int crit_cnt = 0;
  logic [255:0] exp_line = '0;

  always #5 clk = ~clk;

  always @(negedge clk) if (crit_valid === 1'b1) crit_cnt++;

  line_fill_buffer #(.ADDR_W(32), .WORD_W(32), .LINE_WORDS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid    (miss_valid),
    .miss_ready    (miss_ready),
    .miss_addr     (miss_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .crit_valid    (crit_valid),
    .crit_data     (crit_data),
    .fill_valid    (fill_valid),
    .fill_ready    (fill_ready),
    .fill_line     (fill_line),
    .fill_addr     (fill_addr),
    .fill_offset   (fill_offset)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [255:0] l, input int i);
    return l[255-32*i -: 32];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " miss_ready"},    miss_ready,    1);
    check({tag, " mem_req_valid"}, mem_req_valid, 0);
    check({tag, " mem_req_addr"},  mem_req_addr,  0);
    check({tag, " crit_valid"},    crit_valid,    0);
    check({tag, " crit_data"},     crit_data,     0);
    check({tag, " fill_valid"},    fill_valid,    0);
    check({tag, " fill_line"},     fill_line,     0);
    check({tag, " fill_addr"},     fill_addr,     0);
    check({tag, " fill_offset"},   fill_offset,   0);
  endtask

  // One full miss. nbeats < 8 stops early (for the reset-abort case) and skips the fill checks.
  task automatic run_miss(input string tag, input logic [31:0] addr, input logic [31:0] base,
                          input int req_stall, input int gap, input int bp, input int nbeats,
                          input int exp_lat);
    int n;
    int c0;
    int off;
    logic [31:0] req_exp;
    n       = 0;
    c0      = crit_cnt;
    off     = int'(addr[4:2]);
    req_exp = {addr[31:2], 2'b00};
    mem_req_ready = 1'b0;
    fill_ready    = 1'b0;
    miss_valid    = 1'b1;
    miss_addr     = addr;
    check({tag, " miss_ready idle"}, miss_ready, 1);
    tick(); n++;
    miss_valid = 1'b0;
    for (int s = 0; s < req_stall; s++) begin
      check({tag, " req_valid stall"}, mem_req_valid, 1);
      check({tag, " req_addr stall"},  mem_req_addr,  req_exp);
      tick(); n++;
    end
    check({tag, " req_valid"}, mem_req_valid, 1);
    check({tag, " req_addr"},  mem_req_addr,  req_exp);
    check({tag, " miss_ready req"}, miss_ready, 0);
    mem_req_ready = 1'b1;
    tick(); n++;
    mem_req_ready = 1'b0;
    check({tag, " req_valid drop"}, mem_req_valid, 0);
    for (int k = 0; k < nbeats; k++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = base + 32'(k);
      exp_line[255-32*((off+k)%8) -: 32] = base + 32'(k);
      tick(); n++;
      mem_rsp_valid = 1'b0;
      if (k == 0) begin
        check({tag, " crit_valid"}, crit_valid, 1);
        check({tag, " crit_data"},  crit_data,  base);
      end
      if (k < 7) begin
        check({tag, " fill_valid early"}, fill_valid, 0);
        for (int g = 0; g < gap; g++) begin
          tick(); n++;
          check({tag, " fill_valid gap"}, fill_valid, 0);
        end
      end
    end
    if (nbeats == 8) begin
      check({tag, " fill_valid"},  fill_valid,  1);
      check({tag, " fill_lat"},    n,           exp_lat);
      check({tag, " crit_pulses"}, crit_cnt - c0, 1);
      check({tag, " fill_line"},   fill_line,   exp_line);
      check({tag, " fill_addr"},   fill_addr,   {addr[31:5], 5'b0});
      check({tag, " fill_offset"}, fill_offset, addr[4:2]);
      for (int b = 0; b < bp; b++) begin
        miss_valid = 1'b1;
        miss_addr  = 32'hFFFF_FFC4;
        tick();
        check({tag, " bp fill_valid"}, fill_valid, 1);
        check({tag, " bp fill_line"},  fill_line,  exp_line);
        check({tag, " bp fill_addr"},  fill_addr,  {addr[31:5], 5'b0});
        check({tag, " bp miss_ready"}, miss_ready, 0);
        check({tag, " bp req_valid"},  mem_req_valid, 0);
      end
      miss_valid = 1'b0;
      fill_ready = 1'b1;
      tick();
      fill_ready = 1'b0;
      check({tag, " post fill_valid"}, fill_valid,    0);
      check({tag, " post miss_ready"}, miss_ready,    1);
      check({tag, " post req_valid"},  mem_req_valid, 0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    miss_valid    = 1'b0;
    miss_addr     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    fill_ready    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Offset 0, sequential, back-to-back.
    run_miss("off0", 32'h0000_1000, 32'h0000_00A0, 0, 0, 0, 8, 10);
    check("off0 word0", word_of(exp_line, 0), 32'hA0);
    check("off0 word7", word_of(exp_line, 7), 32'hA7);

    // Spurious beats in IDLE must leave everything untouched.
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_0000 + 32'(i);
      tick();
      mem_rsp_valid = 1'b0;
      check("spur crit_valid", crit_valid, 0);
      check("spur fill_valid", fill_valid, 0);
      check("spur fill_line",  fill_line,  exp_line);
      check("spur miss_ready", miss_ready, 1);
    end

    // Offset 7 wraps 7,0,1..6.
    run_miss("wrap", 32'h0000_203C, 32'h0000_00B0, 0, 0, 0, 8, 10);
    check("wrap word7", word_of(fill_line, 7), 32'hB0);
    check("wrap word0", word_of(fill_line, 0), 32'hB1);
    check("wrap word6", word_of(fill_line, 6), 32'hB7);
    check("wrap crit_data", crit_data, 32'hB0);

    // Request stall 3, 2-cycle beat gaps, fill_ready held off 5 cycles.
    run_miss("stall", 32'h0000_4014, 32'h0000_00E0, 3, 2, 5, 8, 27);

    // Abort after four beats.
    run_miss("abort", 32'h0000_5048, 32'h0000_00C0, 0, 0, 0, 4, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_line = '0;
    check_reset_outputs("abort rst");

    // Recovery with a different offset; the full line is compared against fresh data only.
    run_miss("recov", 32'h0000_3048, 32'h0000_00D0, 0, 0, 0, 8, 10);
    check("recov word2", word_of(fill_line, 2), 32'hD0);
    check("recov word1", word_of(fill_line, 1), 32'hD7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Upstream neighbour of the cache's 8-to-1 word-select mux. On a read miss it fetches one 256-bit line from memory as eight 32-bit beats.
- Fetch order is critical-word-first, wrapping within the line. The critical word is forwarded early, then the assembled line is presented to the data array and word-select stage.
- Word k of the line sits at bits [255-32k : 224-32k], so word 0 occupies the MSBs, matching the word-select mux ordering.

Parameters:
- ADDR_W, 32, byte address width. Minimum 6.
- WORD_W, 32, data beat and word width. Fixed for this revision.
- LINE_WORDS, 8, words per line. Fixed; offset field is 3 bits at addr[4:2].

Ports:
- clk  in  1  single clock domain; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_valid  in  1  miss request.
- miss_ready  out  1  high only in IDLE.
- miss_addr  in  ADDR_W  missing byte address.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  {miss_addr[ADDR_W-1:5], offset, 2'b00}; memory returns 8 beats wrapping within the line.
- mem_rsp_valid  in  1  beat valid. No backpressure; the block always sinks beats in FILL.
- mem_rsp_data  in  WORD_W  beat data.
- crit_valid  out  1  one-cycle pulse carrying the critical word.
- crit_data  out  WORD_W  first beat, registered.
- fill_valid  out  1  assembled line available.
- fill_ready  in  1  consumer accepts line.
- fill_line  out  256  assembled line, word 0 at [255:224].
- fill_addr  out  ADDR_W  line-aligned address {tag/index, 5'b0}.
- fill_offset  out  3  original word offset, driven to the word-select mux.

Behaviour:
- Reset values:
  - state = IDLE.
  - miss_ready = 1.
  - mem_req_valid, crit_valid, fill_valid = 0.
  - fill_line, fill_addr, fill_offset, crit_data, mem_req_addr = 0.
  - beat counter = 0.
- FSM states: IDLE, REQ, FILL, DONE.
- IDLE:
  - miss_ready = 1.
  - On miss_valid, latch addr[ADDR_W-1:5] and offset = addr[4:2], clear the beat counter, go to REQ.
  - mem_req_valid rises the next cycle.
- REQ:
  - mem_req_valid = 1, mem_req_addr stable.
  - On mem_req_ready, go to FILL; mem_req_valid drops the following cycle.
- FILL:
  - Each mem_rsp_valid beat with count k (0..7) writes word index (offset + k) mod 8, using 3-bit wrap arithmetic.
  - Beat k=0 also loads crit_data; crit_valid pulses the next cycle.
  - On beat 7, go to DONE.
  - fill_valid = 1 the cycle after the 8th beat is accepted.
- DONE:
  - fill_valid held; fill_line, fill_addr, fill_offset stable until fill_ready.
  - On fill_valid && fill_ready, go to IDLE.
  - The next miss can be accepted no earlier than the cycle after the fill handshake.
- Minimum latency, with mem_req_ready and beats back-to-back and immediate:
  - miss accept at cycle 0.
  - mem_req at cycle 1.
  - beats at cycles 2..9.
  - crit_valid at cycle 3.
  - fill_valid at cycle 10.
- Boundary cases:
  - mem_rsp_valid outside FILL is ignored; no state change, no line write.
  - offset = 7 wraps 7,0,1..6.
  - offset = 0 is sequential fill.
  - Gaps between beats are allowed; the counter advances only on valid beats.
  - fill_ready held high in DONE completes in 1 cycle.
  - miss_valid during REQ/FILL/DONE is ignored (miss_ready = 0); the requester holds it.
  - rst mid-REQ/FILL/DONE: next cycle all outputs at reset values and partial line discarded. The memory side is reset by the same rst, so no stale beats are expected.
  - fill_line words not yet written in FILL hold prior contents. They are never visible because fill_valid = 0.

Decomposition:
- Package lfb_pkg:
  - state enum (IDLE, REQ, FILL, DONE).
  - constants LINE_BITS = 256, OFFSET_W = 3, BYTE_OFF_W = 2.
  - function word_lsb(idx) returning 224 - 32*idx.
- No sub-module required. Optionally split out line_assembler, the beat-to-word write logic with the wrap counter.

Test Plan:
- Offset 0: miss_addr = 32'h0000_1000, beats 32'hA0..A7 back-to-back.
  - mem_req_addr = 32'h0000_1000.
  - crit_data = 32'hA0.
  - fill_line[255:224] = A0 and [31:0] = A7.
  - fill_valid at cycle 10.
- Wrap: miss_addr = 32'h0000_203C (offset 7), beats B0..B7.
  - mem_req_addr = 32'h0000_203C.
  - word7 = B0, word0 = B1, word6 = B7.
  - crit_data = B0.
  - fill_addr = 32'h0000_2020, fill_offset = 7.
- Stalls: mem_req_ready low 3 cycles, beats with 2-cycle gaps.
  - mem_req_valid/addr held stable throughout.
  - Exactly 8 word writes.
  - fill_valid only after the 8th beat.
- Backpressure: fill_ready low 5 cycles.
  - fill_valid and fill_line stable.
  - miss_ready = 0 and a concurrent miss_valid is ignored.
  - After the handshake, miss_ready = 1 next cycle.
- Reset mid-fill: rst asserted after beat 4.
  - Next cycle state IDLE, all outputs at reset values.
  - A new miss then completes with correct data and no residue from the aborted fill.
- Spurious beats: mem_rsp_valid pulses in IDLE.
  - No crit_valid, no fill_valid, line unchanged.
